// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : uart_receiver
//  Brief    : 8N1 UART receiver, 8 clk cycles per bit, single-word holding
//             register with valid/ready handshake, frame-error pulse and
//             overrun flag. Payload bytes are passed through unmodified.
//  Options  : UART_RX_MAJORITY_VOTE_EN - when defined, each bit decision is
//             a 2-of-3 vote over the synchronised line at cnt 2, 3 and 4;
//             otherwise the single sample at cnt 4 is used. Timing is the
//             same in both builds.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_receiver (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Cycle within a bit at which the bit value is decided.
  localparam logic [2:0] C_DECIDE_CNT = 3'd4;
  // Last cycle of a bit period.
  localparam logic [2:0] C_LAST_CNT   = 3'd7;
  // Index of the final data bit (MSB, sent last).
  localparam logic [2:0] C_LAST_BIT   = 3'd7;

  // Two-stage synchroniser for the asynchronous serial line.
  logic       r_sync1;
  logic       r_sync2;
  logic       w_rx_sync;

  // Receive state machine and datapath registers.
  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic [2:0] r_bit_idx;
  logic [2:0] w_bit_idx_nxt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;

  // Per-bit decision and frame completion strobes.
  logic       w_decide;
  logic       w_decision;
  logic       w_word_done;
  logic       w_frame_err;

  assign w_rx_sync = r_sync2;
  assign w_decide  = (r_cnt == C_DECIDE_CNT);

  // Synchronise rx into the clk domain; idle level (1) on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Earlier samples of the bit; the third vote is the live sample at cnt 4.
  logic r_samp2;
  logic r_samp3;

  // Capture the synchronised line at cnt 2 and cnt 3 of every bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp2 <= 1'b1;
      r_samp3 <= 1'b1;
    end else begin
      if (r_cnt == 3'd2) begin
        r_samp2 <= w_rx_sync;
      end
      if (r_cnt == 3'd3) begin
        r_samp3 <= w_rx_sync;
      end
    end
  end

  // 2-of-3 majority rejects a single-cycle disturbance near mid-bit.
  always_comb begin
    w_decision = (r_samp2 & r_samp3) | (r_samp2 & w_rx_sync) | (r_samp3 & w_rx_sync);
  end
`else
  // Single mid-bit sample.
  always_comb begin
    w_decision = w_rx_sync;
  end
`endif

  // FSM state register plus bit counter, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Next-state, counter and shift logic; strobes for word done / frame error.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_word_done   = 1'b0;
    w_frame_err   = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A low line starts a new frame; the start bit is confirmed at cnt 4.
        if (!w_rx_sync) begin
          w_state_nxt   = S_START;
          w_cnt_nxt     = 3'd0;
          w_bit_idx_nxt = 3'd0;
        end
      end

      S_START: begin
        w_cnt_nxt = r_cnt + 3'd1;
        if (w_decide && w_decision) begin
          // Line high again at mid-bit: treat as noise, not a start bit.
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 3'd0;
        end else if (r_cnt == C_LAST_CNT) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = 3'd0;
        end
      end

      S_DATA: begin
        w_cnt_nxt = r_cnt + 3'd1;
        if (w_decide) begin
          // LSB arrives first, so shifting in from the MSB side leaves the
          // byte correctly aligned after eight bits.
          w_shift_nxt = {w_decision, r_shift[7:1]};
        end
        if (r_cnt == C_LAST_CNT) begin
          if (r_bit_idx == C_LAST_BIT) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end

      S_STOP: begin
        w_cnt_nxt = r_cnt + 3'd1;
        if (w_decide) begin
          // Leave mid stop bit so a following start edge is not missed.
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 3'd0;
          if (w_decision) begin
            w_word_done = 1'b1;
          end else begin
            w_frame_err = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Holding register, handshake, overrun flag and frame-error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= w_frame_err;
      if (w_word_done) begin
        // A new word always wins; overrun only if the old one was not taken
        // in this same cycle.
        rx_data    <= r_shift;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid & ~rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
    end
  end

  // Busy whenever a frame is being tracked.
  always_comb begin
    rx_busy = (r_state != S_IDLE);
  end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous reset, active-high.
REQ-003 SHALL have port: rx  input  1  UART serial line, idle high, asynchronous to clk.
REQ-004 SHALL have port: rx_ready  input  1  consumer accepts held word when high with rx_valid.
REQ-005 SHALL have port: rx_data  output  8  last received data byte (Hamming-encoded payload, passed unmodified).
REQ-006 SHALL have port: rx_valid  output  1  rx_data holds an unconsumed word.
REQ-007 SHALL have port: rx_busy  output  1  high whenever FSM not in IDLE.
REQ-008 SHALL have port: rx_frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port: rx_overrun  output  1  new word overwrote an unconsumed word; held until next accept.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (rx_sync) reset to 1; all decisions use rx_sync only.
REQ-011 SHALL use 8 clk cycles per bit and a 3-bit cycle counter cnt (0..7), frame = start, 8 data LSB first, 1 stop.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-013 IDLE: on rx_sync==0 SHALL go to START with cnt=0; else stay.
REQ-014 START/DATA/STOP: cnt SHALL increment every cycle, wrapping 7->0; bit decision taken at cnt==4.
REQ-015 START: decision==1 (false start) SHALL return to IDLE at once; else at cnt==7 go to DATA, bit index 0.
REQ-016 DATA: decision SHALL shift into byte shift register from MSB side (right shift); at cnt==7 with bit index 7 go to STOP, else bit index +1.
REQ-017 STOP: at cnt==4 SHALL return to IDLE at once, enabling back-to-back frames.
REQ-018 Stop decision==1: rx_data SHALL load shift register and rx_valid SHALL be 1 next cycle.
REQ-019 Stop decision==0: rx_frame_err SHALL pulse for one cycle; rx_data, rx_valid unchanged; word discarded.
REQ-020 Latency: with E0 the edge at which IDLE sees rx_sync==0, rx_valid SHALL be high after edge E0+77.
REQ-021 rx_valid && rx_ready SHALL clear rx_valid and rx_overrun next cycle.
REQ-022 Word completes while rx_valid=1 and no accept that cycle: SHALL overwrite rx_data, keep rx_valid=1, set rx_overrun=1.
REQ-023 Word completes in same cycle as accept: SHALL load new data, keep rx_valid=1, rx_overrun=0.
REQ-024 rx_ready while rx_valid=0 SHALL have no effect.
REQ-025 rx_busy SHALL be combinational (state != IDLE).

Reset
REQ-026 rst high SHALL asynchronously force: state IDLE, cnt 0, bit index 0, shift register 0, synchronizer 1s, rx_data 8'h00, rx_valid 0, rx_frame_err 0, rx_overrun 0.
REQ-027 rst mid-frame SHALL abandon the frame with no valid or error output; reception resumes on the next falling edge after release.

Configuration
REQ-028 Macro UART_RX_MAJORITY_VOTE_EN defined: bit decision SHALL be 2-of-3 majority of rx_sync at cnt 2, 3, 4.
REQ-029 Macro undefined: bit decision SHALL be the single rx_sync sample at cnt==4; the timing in REQ-014..REQ-020 is identical in both builds.

Verification
REQ-030 Bench SHALL drive frame 0xA5 (8 cycles/bit, good stop) -> rx_data=0xA5, rx_valid high at E0+77, rx_frame_err=0.
REQ-031 Bench SHALL drive 3-cycle low glitch on idle line -> FSM returns to IDLE from START, no rx_valid, no rx_frame_err.
REQ-032 Bench SHALL drive frame 0x3C with stop bit low -> one-cycle rx_frame_err, rx_valid stays 0.
REQ-033 Bench SHALL drive 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=0x22, rx_valid=1, rx_overrun=1; then rx_ready=1 one cycle -> both clear.
REQ-034 Bench SHALL assert rst at data bit 3 of a frame, release, then send 0x5A -> only 0x5A delivered, no error.
REQ-035 With UART_RX_MAJORITY_VOTE_EN, bench SHALL invert rx for one cycle at cnt 3 of each data bit of 0xF0 -> rx_data=0xF0; without macro, the same glitch placed at cnt 4 -> rx_data=0x0F.
